// File: rtl/seg_write_scheduler.sv
// seg_write_scheduler: round-robin Avalon-MM writer of 7-segment patterns with changed-lane byte enables and hold-off
module seg_write_scheduler #(
  parameter int HOLD_CYCLES = 1000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_value,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_value,
  output logic        req1_ready,
  output logic [3:0]  master_address,
  output logic        master_write,
  output logic [31:0] master_writedata,
  output logic [3:0]  master_byteenable,
  output logic        busy,
  output logic        owner
);
  localparam int CW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef enum logic [1:0] {IDLE, ENCODE, WRITE, HOLD} state_t;
  state_t state;
  logic rr, g0, g1;
  logic [15:0] value;
  logic [31:0] shadow, pat, mask;
  logic [3:0] be;
  logic [CW-1:0] cnt;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign pat[8*i+:8] = {1'b0, SEG[value[4*i+:4]] ^ {7{ACTIVE_LOW}}};
    assign be[i] = pat[8*i+:8] != shadow[8*i+:8];
    assign mask[8*i+:8] = {8{master_byteenable[i]}};
  end
  assign g0 = req0_valid & (~req1_valid | rr);
  assign g1 = req1_valid & (~req0_valid | ~rr);
  assign req0_ready = (state == IDLE) & g0;
  assign req1_ready = (state == IDLE) & g1;
  assign busy = state != IDLE;
  assign master_address = '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr <= 1'b1;
      owner <= 1'b0;
      value <= '0;
      shadow <= '0;
      cnt <= '0;
      master_write <= 1'b0;
      master_writedata <= '0;
      master_byteenable <= '0;
    end else begin
      master_write <= 1'b0;
      case (state)
        IDLE: if (req0_ready | req1_ready) begin
          value <= req1_ready ? req1_value : req0_value;
          owner <= req1_ready;
          rr <= req1_ready;
          state <= ENCODE;
        end
        ENCODE: if (be == '0) state <= IDLE;
        else begin
          master_writedata <= pat;
          master_byteenable <= be;
          master_write <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          shadow <= (shadow & ~mask) | (master_writedata & mask);
          cnt <= CW'(HOLD_CYCLES - 1);
          state <= (HOLD_CYCLES == 0) ? IDLE : HOLD;
        end
        HOLD: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seg_write_scheduler.sv
// tb_seg_write_scheduler: directed checks of arbitration, lane encoding, hold-off and reset
module tb_seg_write_scheduler;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic a_v0 = 0, a_v1 = 0, a_r0, a_r1, a_wr, a_busy, a_own;
  logic [15:0] a_d0 = 0, a_d1 = 0;
  logic [3:0] a_addr, a_be;
  logic [31:0] a_wd;
  logic b_v0 = 0, b_v1 = 0, b_r0, b_r1, b_wr, b_busy, b_own;
  logic [15:0] b_d0 = 0, b_d1 = 0;
  logic [3:0] b_addr, b_be;
  logic [31:0] b_wd;
  seg_write_scheduler #(.HOLD_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(a_v0), .req0_value(a_d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_value(a_d1), .req1_ready(a_r1),
    .master_address(a_addr), .master_write(a_wr), .master_writedata(a_wd),
    .master_byteenable(a_be), .busy(a_busy), .owner(a_own)
  );
  seg_write_scheduler #(.HOLD_CYCLES(0), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(b_v0), .req0_value(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_value(b_d1), .req1_ready(b_r1),
    .master_address(b_addr), .master_write(b_wr), .master_writedata(b_wd),
    .master_byteenable(b_be), .busy(b_busy), .owner(b_own)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    cyc(3);
    reset = 1'b0;
    #1;
    check("rst_wr", a_wr, 0);
    check("rst_wd", a_wd, 0);
    check("rst_be", a_be, 0);
    check("rst_busy", a_busy, 0);
    check("rst_own", a_own, 0);
    check("rst_ready", a_r0, 0);
    a_v0 = 1; a_d0 = 16'h1234;
    #1;
    check("t1_ready", a_r0, 1);
    cyc(1);
    a_v0 = 0;
    check("t1_enc_busy", a_busy, 1);
    check("t1_enc_wr", a_wr, 0);
    cyc(1);
    check("t1_wr", a_wr, 1);
    check("t1_wd", a_wd, 32'h065B4F66);
    check("t1_be", a_be, 4'hF);
    check("t1_addr", a_addr, 0);
    check("t1_own", a_own, 0);
    cyc(1);
    a_v0 = 1; a_d0 = 16'h1235;
    #1;
    check("hold_wr_low", a_wr, 0);
    check("hold_wd_stable", a_wd, 32'h065B4F66);
    for (int i = 0; i < 4; i++) begin
      check("hold_noready", a_r0, 0);
      check("hold_busy", a_busy, 1);
      cyc(1);
    end
    check("hold_release", a_r0, 1);
    cyc(1);
    a_v0 = 0;
    cyc(1);
    check("t2_wr", a_wr, 1);
    check("t2_wd", a_wd, 32'h065B4F6D);
    check("t2_be", a_be, 4'h1);
    cyc(1);
    a_v1 = 1; a_d1 = 16'h1235;
    cyc(3);
    check("t2_hold_r1", a_r1, 0);
    cyc(1);
    check("t2_r1", a_r1, 1);
    cyc(1);
    a_v1 = 0;
    check("t2_own1", a_own, 1);
    cyc(1);
    check("t2_nowrite", a_wr, 0);
    check("t2_idle", a_busy, 0);
    check("t2_be_stable", a_be, 4'h1);
    a_v0 = 1; a_d0 = 16'h5555;
    #1;
    check("t5_ready", a_r0, 1);
    cyc(1);
    a_v0 = 0;
    cyc(1);
    check("t5_wr", a_wr, 1);
    check("t5_wd", a_wd, 32'h6D6D6D6D);
    check("t5_be", a_be, 4'hE);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("t5_rst_busy", a_busy, 0);
    check("t5_rst_wd", a_wd, 0);
    check("t5_rst_be", a_be, 0);
    check("t5_rst_own", a_own, 0);
    a_v0 = 1; a_d0 = 16'hFFFF;
    #1;
    check("t5_ff_ready", a_r0, 1);
    cyc(1);
    a_v0 = 0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("t5_ff_nowr", a_wr, 0);
    check("t5_ff_idle", a_busy, 0);
    cyc(1);
    check("t5_ff_nowr2", a_wr, 0);
    a_v0 = 1; a_d0 = 16'h0000;
    #1;
    check("t5_z_ready", a_r0, 1);
    cyc(1);
    a_v0 = 0;
    cyc(1);
    check("t5_z_wr", a_wr, 1);
    check("t5_z_wd", a_wd, 32'h3F3F3F3F);
    check("t5_z_be", a_be, 4'hF);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    b_v0 = 1; b_d0 = 16'h0123; b_v1 = 1; b_d1 = 16'h4567;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_r0", b_r0, (i % 2) == 0);
      check("rr_r1", b_r1, (i % 2) == 1);
      cyc(2);
      check("rr_wr", b_wr, 1);
      check("rr_wd", b_wd, (i % 2) ? 32'h19120278 : 32'h40792430);
      check("rr_be", b_be, 4'hF);
      check("rr_own", b_own, i % 2);
      cyc(1);
    end
    b_v1 = 0;
    b_v0 = 1; b_d0 = 16'h0001;
    #1;
    check("t6_ready", b_r0, 1);
    cyc(1);
    b_v0 = 0;
    cyc(1);
    check("t6_wr", b_wr, 1);
    check("t6_wd", b_wd, 32'h40404079);
    check("t6_be", b_be, 4'hF);
    cyc(1);
    b_v0 = 1; b_d0 = 16'h8888;
    #1;
    check("t6_8_ready", b_r0, 1);
    cyc(1);
    b_v0 = 0;
    cyc(1);
    check("t6_8_wr", b_wr, 1);
    check("t6_8_wd", b_wd, 32'h00000000);
    check("t6_8_be", b_be, 4'hF);
    check("t6_8_addr", b_addr, 0);
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
